// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_pkg
// Description : Shared types for the vector ALU sequencer. It holds the ALU
//               opcode encoding and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

  // ALU opcode encoding; RSVD is rejected by the sequencer as illegal
  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    MUL  = 2'd2,
    RSVD = 2'd3
  } vop_e;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vseq_state_e;

endpackage
`default_nettype wire

// File: rtl/valu_alu.sv
`default_nettype none
// ============================================================================
// Module      : valu_alu
// Description : Registered element ALU (add/sub/mul) with signed overflow,
//               zero and negative flags. The result and flags are valid one
//               cycle after the operands. It sits beside the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module valu_alu
  import vec_pkg::*;
#(
  parameter int vdw_p      = 32,
  parameter int op_width_p = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [vdw_p-1:0]      a_i,
  input  logic [vdw_p-1:0]      b_i,
  input  logic [op_width_p-1:0] op_i,
  output logic [vdw_p-1:0]      result_o,
  output logic                  overflow_o,
  output logic                  zero_o,
  output logic                  negative_o
);

  localparam logic [op_width_p-1:0] c_op_add = op_width_p'(ADD);
  localparam logic [op_width_p-1:0] c_op_sub = op_width_p'(SUB);
  localparam logic [op_width_p-1:0] c_op_mul = op_width_p'(MUL);

  logic [vdw_p-1:0]   result_d, result_q;
  logic               overflow_d, overflow_q;
  logic [2*vdw_p-1:0] prod;

  // Compute the next result and signed-overflow flag for the selected op
  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    // Sign-extend both operands so the low 2*vdw_p bits hold the signed product
    prod = {{vdw_p{a_i[vdw_p-1]}}, a_i} * {{vdw_p{b_i[vdw_p-1]}}, b_i};
    case (op_i)
      c_op_add: begin
        result_d   = a_i + b_i;
        overflow_d = (a_i[vdw_p-1] == b_i[vdw_p-1]) &&
                     (result_d[vdw_p-1] != a_i[vdw_p-1]);
      end
      c_op_sub: begin
        result_d   = a_i - b_i;
        overflow_d = (a_i[vdw_p-1] != b_i[vdw_p-1]) &&
                     (result_d[vdw_p-1] != a_i[vdw_p-1]);
      end
      c_op_mul: begin
        result_d   = prod[vdw_p-1:0];
        // The product fits only if the upper half is pure sign extension
        overflow_d = (prod[2*vdw_p-1:vdw_p] != {vdw_p{prod[vdw_p-1]}});
      end
      default: begin
        result_d   = '0;
        overflow_d = 1'b0;
      end
    endcase
  end

  // Register the result and overflow flag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result_o   = result_q;
  assign overflow_o = overflow_q;
  assign zero_o     = (result_q == '0);
  assign negative_o = result_q[vdw_p-1];

endmodule
`default_nettype wire

// File: rtl/valu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : valu_sequencer
// Description : Vector instruction sequencer. It accepts one vector op,
//               streams element reads from the register file, routes operands
//               to an external registered ALU, and writes results back with a
//               two-cycle read-to-write latency at one element per cycle.
//               Completion status is accumulated per instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module valu_sequencer
  import vec_pkg::*;
#(
  parameter int vdw_p       = 32,
  parameter int op_width_p  = 2,
  parameter int vlen_p      = 8,
  parameter int num_vregs_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [op_width_p-1:0]          op_i,
  input  logic [$clog2(num_vregs_p)-1:0] vs1_i,
  input  logic [$clog2(num_vregs_p)-1:0] vs2_i,
  input  logic [$clog2(num_vregs_p)-1:0] vd_i,
  input  logic [$clog2(vlen_p+1)-1:0]    len_i,
  output logic [$clog2(vlen_p)-1:0]      rf_r_elem_o,
  output logic [$clog2(num_vregs_p)-1:0] rf_rs1_o,
  output logic [$clog2(num_vregs_p)-1:0] rf_rs2_o,
  input  logic [vdw_p-1:0]               rf_rs1_data_i,
  input  logic [vdw_p-1:0]               rf_rs2_data_i,
  output logic [vdw_p-1:0]               alu_a_o,
  output logic [vdw_p-1:0]               alu_b_o,
  output logic [op_width_p-1:0]          alu_op_o,
  input  logic [vdw_p-1:0]               alu_result_i,
  input  logic                           alu_flag_overflow_i,
  input  logic                           alu_flag_zero_i,
  input  logic                           alu_flag_negative_i,
  output logic                           rf_w_v_o,
  output logic [$clog2(num_vregs_p)-1:0] rf_w_reg_o,
  output logic [$clog2(vlen_p)-1:0]      rf_w_elem_o,
  output logic [vdw_p-1:0]               rf_w_data_o,
  output logic                           done_o,
  output logic                           illegal_o,
  output logic                           ovf_o,
  output logic                           neg_o,
  output logic                           zero_o
);

  localparam int reg_w  = $clog2(num_vregs_p);
  localparam int elem_w = $clog2(vlen_p);
  localparam int len_w  = $clog2(vlen_p+1);

  localparam logic [op_width_p-1:0] c_op_rsvd = op_width_p'(RSVD);
  localparam logic [len_w-1:0]      c_len_max = len_w'(vlen_p);

  vseq_state_e state_d, state_q;

  logic [op_width_p-1:0] op_d, op_q;
  logic [reg_w-1:0]      vs1_d, vs1_q;
  logic [reg_w-1:0]      vs2_d, vs2_q;
  logic [reg_w-1:0]      vd_d, vd_q;
  logic [len_w-1:0]      len_d, len_q;
  logic [elem_w-1:0]     elem_d, elem_q;

  logic                  s1_v_d, s1_v_q;
  logic [elem_w-1:0]     s1_elem_d, s1_elem_q;
  logic                  s2_v_d, s2_v_q;
  logic [elem_w-1:0]     s2_elem_d, s2_elem_q;

  logic                  illegal_d, illegal_q;
  logic                  ovf_d, ovf_q;
  logic                  neg_d, neg_q;
  logic                  zero_d, zero_q;

  logic                  accept;
  logic                  rd_fire;
  logic                  is_noop;
  logic [len_w-1:0]      len_eff;
  logic [elem_w-1:0]     last_elem;

  // Ready only in IDLE and never while reset is held
  assign ready_o   = (state_q == IDLE) && !reset_i;
  assign accept    = v_i && ready_o;
  // A read is issued every cycle spent in RUN
  assign rd_fire   = (state_q == RUN);
  // Zero-length or reserved-op instructions complete without touching the RF
  assign is_noop   = (len_i == '0) || (op_i == c_op_rsvd);
  // Requests longer than the register length are clamped
  assign len_eff   = (len_i > c_len_max) ? c_len_max : len_i;
  assign last_elem = elem_w'(len_q - len_w'(1));

  // Next-state logic for the sequencer FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_noop) state_d = DONE;
          else         state_d = RUN;
        end
      end
      RUN: begin
        if (elem_q == last_elem) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave once the pipeline will be empty, so done follows the last write
        if (!s1_v_d && !s2_v_d) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values for latched instruction fields, element counter, pipeline and status
  always_comb begin
    op_d      = op_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    vd_d      = vd_q;
    len_d     = len_q;
    elem_d    = elem_q;
    s1_v_d    = rd_fire;
    s1_elem_d = elem_q;
    s2_v_d    = s1_v_q;
    s2_elem_d = s1_elem_q;
    illegal_d = illegal_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    zero_d    = zero_q;

    if (rd_fire && (elem_q != last_elem)) begin
      elem_d = elem_q + 1'b1;
    end

    // Fold the flags of every written element into the completion status
    if (s2_v_q) begin
      ovf_d  = ovf_q  | alu_flag_overflow_i;
      neg_d  = neg_q  | alu_flag_negative_i;
      zero_d = zero_q & alu_flag_zero_i;
    end

    if (accept) begin
      op_d      = op_i;
      vs1_d     = vs1_i;
      vs2_d     = vs2_i;
      vd_d      = vd_i;
      len_d     = len_eff;
      elem_d    = '0;
      illegal_d = (op_i == c_op_rsvd);
      ovf_d     = 1'b0;
      neg_d     = 1'b0;
      zero_d    = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath, pipeline and status registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      len_q     <= '0;
      elem_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_elem_q <= '0;
      s2_v_q    <= 1'b0;
      s2_elem_q <= '0;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      op_q      <= op_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      vd_q      <= vd_d;
      len_q     <= len_d;
      elem_q    <= elem_d;
      s1_v_q    <= s1_v_d;
      s1_elem_q <= s1_elem_d;
      s2_v_q    <= s2_v_d;
      s2_elem_q <= s2_elem_d;
      illegal_q <= illegal_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
    end
  end

  // Read port drives are idle-zero outside RUN
  assign rf_r_elem_o = rd_fire ? elem_q : '0;
  assign rf_rs1_o    = rd_fire ? vs1_q  : '0;
  assign rf_rs2_o    = rd_fire ? vs2_q  : '0;

  // Stage 1: read data arrives one cycle after the address
  assign alu_a_o     = s1_v_q ? rf_rs1_data_i : '0;
  assign alu_b_o     = s1_v_q ? rf_rs2_data_i : '0;
  assign alu_op_o    = s1_v_q ? op_q          : '0;

  // Stage 2: the ALU result is written back in the cycle it becomes valid
  assign rf_w_v_o    = s2_v_q;
  assign rf_w_reg_o  = s2_v_q ? vd_q         : '0;
  assign rf_w_elem_o = s2_v_q ? s2_elem_q    : '0;
  assign rf_w_data_o = s2_v_q ? alu_result_i : '0;

  assign done_o      = (state_q == DONE);
  assign illegal_o   = illegal_q;
  assign ovf_o       = ovf_q;
  assign neg_o       = neg_q;
  assign zero_o      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_valu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_valu_sequencer
// Description : Self-checking bench for valu_sequencer with the real ALU and
//               a synchronous-read register file model. Expected results come
//               from an element-wise arithmetic model over a shadow RF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_valu_sequencer;
  import vec_pkg::*;

  localparam int VDW  = 32;
  localparam int OPW  = 2;
  localparam int VLEN = 8;
  localparam int NREG = 8;
  localparam int RW   = 3;
  localparam int EW   = 3;
  localparam int LW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            v, ready;
  logic [OPW-1:0]  op;
  logic [RW-1:0]   vs1, vs2, vd;
  logic [LW-1:0]   len;
  logic [EW-1:0]   r_elem;
  logic [RW-1:0]   rs1, rs2;
  logic [VDW-1:0]  rs1_data, rs2_data;
  logic [VDW-1:0]  alu_a, alu_b, alu_res;
  logic [OPW-1:0]  alu_op;
  logic            alu_ovf, alu_zero, alu_neg;
  logic            w_v;
  logic [RW-1:0]   w_reg;
  logic [EW-1:0]   w_elem;
  logic [VDW-1:0]  w_data;
  logic            done, ill, ovf, neg, zero;

  valu_sequencer #(.vdw_p(VDW), .op_width_p(OPW), .vlen_p(VLEN), .num_vregs_p(NREG)) dut (
    .clk_i(clk), .reset_i(rst), .v_i(v), .ready_o(ready), .op_i(op),
    .vs1_i(vs1), .vs2_i(vs2), .vd_i(vd), .len_i(len),
    .rf_r_elem_o(r_elem), .rf_rs1_o(rs1), .rf_rs2_o(rs2),
    .rf_rs1_data_i(rs1_data), .rf_rs2_data_i(rs2_data),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_result_i(alu_res),
    .alu_flag_overflow_i(alu_ovf), .alu_flag_zero_i(alu_zero), .alu_flag_negative_i(alu_neg),
    .rf_w_v_o(w_v), .rf_w_reg_o(w_reg), .rf_w_elem_o(w_elem), .rf_w_data_o(w_data),
    .done_o(done), .illegal_o(ill), .ovf_o(ovf), .neg_o(neg), .zero_o(zero)
  );

  valu_alu #(.vdw_p(VDW), .op_width_p(OPW)) u_alu (
    .clk_i(clk), .reset_i(rst), .a_i(alu_a), .b_i(alu_b), .op_i(alu_op),
    .result_o(alu_res), .overflow_o(alu_ovf), .zero_o(alu_zero), .negative_o(alu_neg)
  );

  // Register file model: synchronous read, write port plus a bench preload port
  logic [VDW-1:0] rf_mem [NREG][VLEN];
  logic           pl_we = 1'b0;
  logic [RW-1:0]  pl_reg = '0;
  logic [EW-1:0]  pl_elem = '0;
  logic [VDW-1:0] pl_data = '0;
  always @(posedge clk) begin
    rs1_data <= rf_mem[rs1][r_elem];
    rs2_data <= rf_mem[rs2][r_elem];
    if (w_v)   rf_mem[w_reg][w_elem] <= w_data;
    if (pl_we) rf_mem[pl_reg][pl_elem] <= pl_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log writes, accepts and completions
  int w_cyc[$];
  int w_reg_q[$];
  int w_el_q[$];
  logic [VDW-1:0] w_dat_q[$];
  int n_acc = 0, n_done = 0, n_wr_total = 0;
  int acc_cyc = 0, acc_idx = 0;
  int d_cyc = 0, d_acc_cyc = 0, d_lo = 0, d_hi = 0;
  logic d_ill = 0, d_ovf = 0, d_neg = 0, d_zero = 0;
  always @(negedge clk) begin
    if (w_v) begin
      w_cyc.push_back(cyc);
      w_reg_q.push_back(int'(w_reg));
      w_el_q.push_back(int'(w_elem));
      w_dat_q.push_back(w_data);
      n_wr_total <= n_wr_total + 1;
    end
    if (!rst && v && ready) begin
      n_acc   <= n_acc + 1;
      acc_cyc <= cyc;
      acc_idx <= w_cyc.size();
    end
    if (done) begin
      n_done    <= n_done + 1;
      d_cyc     <= cyc;
      d_acc_cyc <= acc_cyc;
      d_lo      <= acc_idx;
      d_hi      <= w_cyc.size();
      d_ill     <= ill;
      d_ovf     <= ovf;
      d_neg     <= neg;
      d_zero    <= zero;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: shadow RF and expectations for the current instruction
  logic [VDW-1:0] sh [NREG][VLEN];
  logic [VDW-1:0] e_res [VLEN];
  int   e_nw, e_vd, exp_total = 0;
  logic e_ill, e_ovf, e_neg, e_zero;

  task automatic model(input int mop, input int m1, input int m2, input int md, input int mlen);
    logic [VDW-1:0] r [VLEN];
    longint sa, sb, full;
    int eff;
    eff    = (mlen > VLEN) ? VLEN : mlen;
    e_nw   = (mop == 3) ? 0 : eff;
    e_vd   = md;
    e_ill  = (mop == 3);
    e_ovf  = 1'b0;
    e_neg  = 1'b0;
    e_zero = 1'b1;
    for (int i = 0; i < e_nw; i++) begin
      sa = longint'($signed(sh[m1][i]));
      sb = longint'($signed(sh[m2][i]));
      case (mop)
        0:       full = sa + sb;
        1:       full = sa - sb;
        default: full = sa * sb;
      endcase
      r[i] = full[31:0];
      if (full != longint'($signed(r[i]))) e_ovf = 1'b1;
      if (r[i][31]) e_neg = 1'b1;
      if (r[i] != '0) e_zero = 1'b0;
    end
    // All sources are read before any destination element changes
    for (int i = 0; i < e_nw; i++) begin
      e_res[i]   = r[i];
      sh[md][i]  = r[i];
    end
    exp_total += e_nw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int pr, input int pe, input logic [VDW-1:0] pd);
    pl_we   = 1'b1;
    pl_reg  = RW'(pr);
    pl_elem = EW'(pe);
    pl_data = pd;
    sh[pr][pe] = pd;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic drive(input int dop, input int d1, input int d2, input int dd, input int dlen);
    op  = OPW'(dop);
    vs1 = RW'(d1);
    vs2 = RW'(d2);
    vd  = RW'(dd);
    len = LW'(dlen);
  endtask

  task automatic wait_accept();
    int prev = n_acc;
    int k = 0;
    while (n_acc == prev && k < 100) begin
      tick();
      k++;
    end
    check_eq("accept_seen", 64'(n_acc != prev), 1);
  endtask

  task automatic wait_done();
    int prev = n_done;
    int k = 0;
    while (n_done == prev && k < 100) begin
      tick();
      k++;
    end
    check_eq("done_seen", 64'(n_done != prev), 1);
  endtask

  task automatic verify(input string nm);
    int n = d_hi - d_lo;
    check_eq({nm, ".nwr"}, n, e_nw);
    for (int i = 0; i < n && i < e_nw; i++) begin
      check_eq({nm, ".wreg"}, w_reg_q[d_lo+i], e_vd);
      check_eq({nm, ".welem"}, w_el_q[d_lo+i], i);
      check_eq({nm, ".wdata"}, w_dat_q[d_lo+i], e_res[i]);
      check_eq({nm, ".wcyc"}, w_cyc[d_lo+i], d_acc_cyc + 3 + i);
    end
    check_eq({nm, ".done_cyc"}, d_cyc, d_acc_cyc + ((e_nw == 0) ? 1 : e_nw + 3));
    check_eq({nm, ".status"}, {d_ill, d_ovf, d_neg, d_zero}, {e_ill, e_ovf, e_neg, e_zero});
    for (int i = 0; i < VLEN; i++) check_eq({nm, ".rf"}, rf_mem[e_vd][i], sh[e_vd][i]);
    check_eq({nm, ".total_wr"}, n_wr_total, exp_total);
  endtask

  task automatic run(input string nm, input int rop, input int r1, input int r2, input int rd, input int rlen);
    model(rop, r1, r2, rd, rlen);
    drive(rop, r1, r2, rd, rlen);
    v = 1'b1;
    wait_accept();
    v = 1'b0;
    wait_done();
    verify(nm);
  endtask

  function automatic logic [VDW-1:0] rnd();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 20)) - 32'd10;
      2:       return 32'h7fff_fff0 + 32'($urandom_range(0, 31));
      3:       return 32'd0;
      default: return 32'($urandom_range(0, 5));
    endcase
  endfunction

  int snap_wr, snap_done, first_done;

  initial begin
    v = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int r = 0; r < NREG; r++)
      for (int e = 0; e < VLEN; e++) preload(r, e, rnd());

    // Outputs while reset is held
    @(negedge clk);
    check_eq("rst.ready", ready, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.wv", w_v, 0);
    check_eq("rst.status", {ill, ovf, neg, zero}, 0);
    check_eq("rst.alu", {alu_a, alu_b}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst.ready", ready, 1);
    tick();

    // Directed add, len 4
    for (int i = 0; i < 4; i++) begin
      preload(1, i, 32'(i + 1));
      preload(2, i, 32'd1);
    end
    run("add4", 0, 1, 2, 3, 4);

    // Directed sub, len 2: negative result
    preload(4, 0, 32'd10); preload(4, 1, 32'd4);
    preload(5, 0, 32'd8);  preload(5, 1, 32'd10);
    run("sub2", 1, 4, 5, 6, 2);

    // In-place square, including 65536*65536
    preload(7, 0, 32'd3);     preload(7, 1, 32'd11);
    preload(7, 2, 32'd5);     preload(7, 3, 32'd65536);
    preload(7, 4, 32'd2);     preload(7, 5, 32'd7);
    preload(7, 6, 32'd1);     preload(7, 7, 32'd9);
    run("mul8", 2, 7, 7, 7, 8);

    // Reserved op and zero length
    run("rsvd", 3, 1, 2, 0, 5);
    run("len0", 0, 1, 2, 0, 0);
    // Over-length request clamps to the register length
    run("clamp", 0, 1, 2, 4, 13);

    // Reset two cycles into a len-8 run
    snap_wr   = n_wr_total;
    snap_done = n_done;
    drive(0, 1, 2, 5, 8);
    v = 1'b1;
    wait_accept();
    v = 1'b0;
    tick();
    #2 rst = 1'b1;
    @(negedge clk);
    check_eq("abort.ready", ready, 0);
    check_eq("abort.outs", {w_v, done, ill, ovf, neg, zero}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort.ready_after", ready, 1);
    repeat (6) tick();
    check_eq("abort.no_writes", n_wr_total, snap_wr);
    check_eq("abort.no_done", n_done, snap_done);
    for (int i = 0; i < VLEN; i++) check_eq("abort.rf", rf_mem[5][i], sh[5][i]);
    run("post_abort_add", 0, 3, 6, 0, 6);

    // v held high across completion; second op consumes the first's result
    model(0, 1, 2, 3, 5);
    drive(0, 1, 2, 3, 5);
    v = 1'b1;
    wait_accept();
    drive(2, 3, 3, 1, 6);
    wait_done();
    verify("b2b_a");
    first_done = d_cyc;
    model(2, 3, 3, 1, 6);
    wait_accept();
    check_eq("b2b.gap", 64'(acc_cyc > first_done), 1);
    v = 1'b0;
    wait_done();
    verify("b2b_b");

    // Randomized instructions
    for (int t = 0; t < 40; t++) begin
      int rop, rlen, rr;
      if ($urandom_range(0, 3) == 0) begin
        rr = $urandom_range(0, NREG - 1);
        for (int e = 0; e < VLEN; e++) preload(rr, e, rnd());
      end
      rop  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      rlen = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      run("rand", rop, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
          $urandom_range(0, NREG - 1), rlen);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/valu_sequencer.md
VALU_SEQUENCER -- requirements
Module: valu_sequencer

Interface
REQ-001 Parameters, one per line:
- vdw_p, 32, element data width.
- op_width_p, 2, opcode width.
- vlen_p, 8, max elements per vector.
- num_vregs_p, 8, vector register count.
REQ-002 Ports (name, direction, width, meaning):
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  1  instruction valid.
- ready_o  out  1  sequencer can accept an instruction.
- op_i  in  op_width_p  0 add, 1 sub, 2 mul, 3 reserved.
- vs1_i, vs2_i, vd_i  in  clog2(num_vregs_p)  source and destination registers.
- len_i  in  clog2(vlen_p+1)  element count.
- rf_r_elem_o  out  clog2(vlen_p)  read element index.
- rf_rs1_o, rf_rs2_o  out  clog2(num_vregs_p)  read registers.
- rf_rs1_data_i, rf_rs2_data_i  in  vdw_p  read data, valid 1 cycle after the address.
- alu_a_o, alu_b_o  out  vdw_p  ALU operands.
- alu_op_o  out  op_width_p  ALU opcode.
- alu_result_i  in  vdw_p  registered ALU result, valid 1 cycle after operands.
- alu_flag_overflow_i, alu_flag_zero_i, alu_flag_negative_i  in  1  per-result ALU flags.
- rf_w_v_o  out  1  write enable.
- rf_w_reg_o  out  clog2(num_vregs_p)  write register.
- rf_w_elem_o  out  clog2(vlen_p)  write element.
- rf_w_data_o  out  vdw_p  write data.
- done_o  out  1  one-cycle completion pulse.
- illegal_o, ovf_o, neg_o, zero_o  out  1  completion status, held until the next accept.

Function
REQ-003 The FSM SHALL have four states, IDLE, RUN, DRAIN and DONE; ready_o SHALL be 1 only in IDLE.
REQ-004 Accept occurs when v_i and ready_o are both 1; op, vs1, vs2, vd and len SHALL be latched on accept, and the inputs are ignored otherwise.
REQ-005 Accept with len_i==0 or op_i==3 SHALL go to DONE with no reads and no writes; illegal_o SHALL be 1 when op_i==3.
REQ-006 Accept with len_i greater than vlen_p SHALL be treated as len=vlen_p.
REQ-007 In RUN, element index e SHALL issue one read per cycle, from 0 up to len-1; the state SHALL become DRAIN in the cycle after read len-1 is issued.
REQ-008 Stage 1: one cycle after read e, alu_a_o/alu_b_o SHALL equal rf_rs1_data_i/rf_rs2_data_i, alu_op_o SHALL equal the latched op, and stage 1 is valid.
REQ-009 Stage 2: one cycle after stage 1, rf_w_v_o SHALL be 1 with rf_w_reg_o=vd, rf_w_elem_o=e and rf_w_data_o=alu_result_i, combinational from the stage-2 valid bit.
REQ-010 Read-to-write latency SHALL be 2 cycles, with throughput of 1 element per cycle and no bubbles.
REQ-011 The state SHALL leave DRAIN for DONE when both pipeline valid bits are 0; DONE SHALL last one cycle, assert done_o, and then return to IDLE.
REQ-012 Status SHALL be cleared on accept and accumulate on each write:
- ovf_o is the OR of alu_flag_overflow_i.
- neg_o is the OR of alu_flag_negative_i.
- zero_o is the AND of alu_flag_zero_i, and is 1 for len=0.
REQ-013 Using vd equal to vs1 or vs2 SHALL be legal; each element is read before it is written.
REQ-014 Back-to-back instructions SHALL have a minimum of 1 idle cycle between done_o and the next accept.

Reset
REQ-015 reset_i SHALL asynchronously force state IDLE and clear both pipeline valid bits and the element counter.
REQ-016 While reset_i is asserted, all outputs SHALL be 0 except ready_o, which SHALL be 1 only once reset_i is deasserted.
REQ-017 Reset during RUN or DRAIN SHALL abort the instruction: no further rf_w_v_o and no done_o.

Structure
REQ-018 Package vec_pkg SHALL hold the opcode enum (ADD=0, SUB=1, MUL=2, RSVD=3) and the FSM state enum.
REQ-019 The ALU is instantiated beside the sequencer, not inside it; no sub-module is required.

Verification
REQ-020 The bench SHALL use the real alu and a synchronous-read register file model.
- Add, len 4: vs1={1,2,3,4}, vs2={1,1,1,1} -> vd={2,3,4,5}; writes on 4 consecutive cycles; first write 2 cycles after the first read; done_o 1 cycle after the last write; zero_o=0.
- Sub, len 2: vs1={10,4}, vs2={8,10} -> {2,-6}; neg_o=1.
- Mul, len 8: vs1=vs2=vd={3,11,...}, in place -> {9,121,...}; ovf_o=1 when 65536*65536 is included.
- op 3, or len 0: done_o 1 cycle after accept; no rf_w_v_o; illegal_o=1 for op 3; zero_o=1 for len 0.
- Reset asserted 2 cycles into a len-8 run: no writes after the reset edge; ready_o=1 after release; a new add completes correctly.
- v_i held high across completion: second accept occurs only in IDLE after done_o; both instructions' results are correct.
